rf_path_seq_ctrl: RTL and testbench

Parametrised multi-channel successor of the single-channel RF front-end I/O controller. It sits on the same 5-bit IOC register bus and holds one RF mode per channel. On every mode change it drives the switch and amplifier pins through a timed break-before-make sequence: amplifiers off, then path switches, then amplifiers on. A compile-time debug override allows raw pin-level control.

---
 rtl/rf_path_seq_ctrl_pkg.sv | 53 +++++
 rtl/rf_path_seq_ctrl_if.sv | 19 +
 rtl/rf_path_seq.sv | 93 +++++++++
 rtl/rf_path_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_rf_path_seq_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/rf_path_seq_ctrl_pkg.sv
// Shared constants, encodings and the mode-to-pin-pattern mapping for the
// multi-channel RF path sequencer.
package rf_ctrl_pkg;

   localparam logic [4:0] IOC_VERSION = 5'h00;
   localparam logic [4:0] IOC_CH_SEL  = 5'h01;
   localparam logic [4:0] IOC_MODE    = 5'h02;
   localparam logic [4:0] IOC_RF_PIN  = 5'h03;
   localparam logic [4:0] IOC_STATUS  = 5'h04;

   localparam logic [7:0] VERSION   = 8'h02;
   localparam logic [2:0] SAFE_MASK = 3'b110;

   typedef enum logic [2:0] {
      RF_LOW_POWER = 3'b000,
      RF_BYPASS    = 3'b001,
      RF_RX_LPF    = 3'b010,
      RF_RX_HPF    = 3'b011,
      RF_TX_LPF    = 3'b100,
      RF_TX_HPF    = 3'b101,
      RF_RSVD6     = 3'b110,
      RF_RSVD7     = 3'b111
   } rf_mode_e;

   typedef enum logic [1:0] {
      DBG_NONE  = 2'b00,
      DBG_PIN   = 2'b01,
      DBG_RSVD2 = 2'b10,
      DBG_RSVD3 = 2'b11
   } dbg_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SAFE,
      ST_SWITCH,
      ST_ENABLE
   } seq_state_e;

   // Reserved mode codes fall back to the low-power pattern.
   function automatic logic [7:0] mode_pattern(input logic [2:0] mode);
      logic [7:0] pat;
      case (mode)
         RF_BYPASS: pat = 8'h66;
         RF_RX_LPF: pat = 8'h9D;
         RF_RX_HPF: pat = 8'h5D;
         RF_TX_LPF: pat = 8'h6B;
         RF_TX_HPF: pat = 8'hAB;
         default:   pat = 8'h56;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/rf_path_seq_ctrl_if.sv
// IOC register bus shared by the RF path sequencer and its host.
interface rf_path_seq_ctrl_if;
   logic [4:0] i_ioc;
   logic [7:0] i_data_in;
   logic [7:0] o_data_out;
   logic       i_cs;
   logic       i_fetch_cmd;
   logic       i_load_cmd;

   modport master (
      output i_ioc, i_data_in, i_cs, i_fetch_cmd, i_load_cmd,
      input  o_data_out
   );

   modport slave (
      input  i_ioc, i_data_in, i_cs, i_fetch_cmd, i_load_cmd,
      output o_data_out
   );
endinterface

// File: rtl/rf_path_seq.sv
// Single-channel break-before-make sequencer: amplifiers off (SAFE), switch
// paths (SWITCH), amplifiers on (ENABLE), with a raw-pin debug override.
module rf_path_seq
   import rf_ctrl_pkg::*;
#(
   parameter int unsigned GUARD_CYC  = 4,
   parameter int unsigned SETTLE_CYC = 16
) (
   input  logic       i_sys_clk,
   input  logic       i_rst,
   input  logic       mode_wr,
   input  logic [7:0] mode_tgt,
   input  logic       dbg_on,
   input  logic [7:0] dbg_pins,
   output logic [7:0] pins,
   output logic       busy
);

   localparam int unsigned CNT_MAX = (GUARD_CYC > SETTLE_CYC) ? GUARD_CYC : SETTLE_CYC;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);

   seq_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    cur_q, cur_d;
   logic [7:0]    tgt_q, tgt_d;
   logic [7:0]    pins_q, pins_d;

   always_ff @(posedge i_sys_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         cur_q   <= mode_pattern(RF_LOW_POWER);
         tgt_q   <= mode_pattern(RF_LOW_POWER);
         pins_q  <= mode_pattern(RF_LOW_POWER);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cur_q   <= cur_d;
         tgt_q   <= tgt_d;
         pins_q  <= pins_d;
      end
   end

   // Pins are registered so that a restart can hold whatever switch bits are
   // being driven at that moment, whichever phase the channel was in.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cur_d   = cur_q;
      tgt_d   = tgt_q;
      pins_d  = pins_q;
      if (dbg_on) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         cur_d   = dbg_pins;
         tgt_d   = dbg_pins;
         pins_d  = dbg_pins;
      end else if (mode_wr && ((state_q != ST_IDLE) || (mode_tgt != cur_q))) begin
         state_d = ST_SAFE;
         cnt_d   = CW'(GUARD_CYC - 1);
         tgt_d   = mode_tgt;
         pins_d  = {pins_q[7:3], SAFE_MASK};
      end else begin
         case (state_q)
            ST_IDLE: pins_d = cur_q;
            ST_SAFE: begin
               if (cnt_q == '0) begin
                  state_d = ST_SWITCH;
                  cnt_d   = CW'(SETTLE_CYC - 1);
                  pins_d  = {tgt_q[7:3], SAFE_MASK};
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            ST_SWITCH: begin
               if (cnt_q == '0) begin
                  state_d = ST_ENABLE;
                  pins_d  = tgt_q;
                  cur_d   = tgt_q;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            ST_ENABLE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   assign pins = pins_q;
   assign busy = (state_q != ST_IDLE);

endmodule

// File: rtl/rf_path_seq_ctrl.sv
// Multi-channel RF front-end controller: IOC register decode plus one
// rf_path_seq per channel. Define RF_PATH_DEBUG_EN for raw-pin debug control.
module rf_path_seq_ctrl
   import rf_ctrl_pkg::*;
#(
   parameter int unsigned N_CH       = 2,
   parameter int unsigned GUARD_CYC  = 4,
   parameter int unsigned SETTLE_CYC = 16
) (
   input  logic                i_sys_clk,
   input  logic                i_rst,
   rf_path_seq_ctrl_if.slave   bus,
   output logic [8*N_CH-1:0]   o_rf_pins,
   output logic [N_CH-1:0]     o_busy
);

   logic              rd_en, wr_en;
   logic [2:0]        ch_sel_q;
   logic [7:0]        data_out_q;
   logic [7:0]        rd_data;
   logic [8*N_CH-1:0] mode_rd;
   logic [7:0]        mode_tgt;
`ifdef RF_PATH_DEBUG_EN
   logic [8*N_CH-1:0] pin_rd;
`endif

   // Fetch wins over load when both strobes are present.
   assign rd_en    = bus.i_cs && bus.i_fetch_cmd;
   assign wr_en    = bus.i_cs && bus.i_load_cmd && !bus.i_fetch_cmd;
   assign mode_tgt = mode_pattern(bus.i_data_in[4:2]);

   always_ff @(posedge i_sys_clk) begin
      if (i_rst) begin
         ch_sel_q <= '0;
      end else if (wr_en && (bus.i_ioc == IOC_CH_SEL) && (bus.i_data_in < 8'(N_CH))) begin
         ch_sel_q <= bus.i_data_in[2:0];
      end
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      logic       sel, mode_wr, dbg_on;
      logic [7:0] dbg_pins;
      logic [2:0] rf_mode_q;

      assign sel     = (ch_sel_q == 3'(k));
      assign mode_wr = wr_en && (bus.i_ioc == IOC_MODE) && sel;

      always_ff @(posedge i_sys_clk) begin
         if (i_rst) begin
            rf_mode_q <= '0;
         end else if (mode_wr) begin
            rf_mode_q <= bus.i_data_in[4:2];
         end
      end

`ifdef RF_PATH_DEBUG_EN
      logic       pin_wr;
      logic [1:0] dbg_q;
      logic [7:0] rf_pin_q;

      assign pin_wr = wr_en && (bus.i_ioc == IOC_RF_PIN) && sel;

      always_ff @(posedge i_sys_clk) begin
         if (i_rst) begin
            dbg_q    <= '0;
            rf_pin_q <= '0;
         end else begin
            if (mode_wr) dbg_q    <= bus.i_data_in[1:0];
            if (pin_wr)  rf_pin_q <= bus.i_data_in;
         end
      end

      // Use the incoming write values so debug pins appear one cycle after the write.
      assign dbg_on   = mode_wr ? (bus.i_data_in[1:0] == DBG_PIN) : (dbg_q == DBG_PIN);
      assign dbg_pins = pin_wr ? bus.i_data_in : rf_pin_q;
      assign mode_rd[8*k +: 8] = {3'b000, rf_mode_q, dbg_q};
      assign pin_rd[8*k +: 8]  = rf_pin_q;
`else
      assign dbg_on   = 1'b0;
      assign dbg_pins = '0;
      assign mode_rd[8*k +: 8] = {3'b000, rf_mode_q, 2'b00};
`endif

      rf_path_seq #(
         .GUARD_CYC  (GUARD_CYC),
         .SETTLE_CYC (SETTLE_CYC)
      ) u_seq (
         .i_sys_clk (i_sys_clk),
         .i_rst     (i_rst),
         .mode_wr   (mode_wr),
         .mode_tgt  (mode_tgt),
         .dbg_on    (dbg_on),
         .dbg_pins  (dbg_pins),
         .pins      (o_rf_pins[8*k +: 8]),
         .busy      (o_busy[k])
      );
   end

   always_comb begin
      rd_data = '0;
      case (bus.i_ioc)
         IOC_VERSION: rd_data = VERSION;
         IOC_CH_SEL:  rd_data = {5'b00000, ch_sel_q};
         IOC_MODE: begin
            for (int unsigned k = 0; k < N_CH; k++) begin
               if (ch_sel_q == 3'(k)) rd_data = mode_rd[8*k +: 8];
            end
         end
`ifdef RF_PATH_DEBUG_EN
         IOC_RF_PIN: begin
            for (int unsigned k = 0; k < N_CH; k++) begin
               if (ch_sel_q == 3'(k)) rd_data = pin_rd[8*k +: 8];
            end
         end
`endif
         IOC_STATUS:  rd_data[N_CH-1:0] = o_busy;
         default:     rd_data = '0;
      endcase
   end

   always_ff @(posedge i_sys_clk) begin
      if (i_rst) begin
         data_out_q <= '0;
      end else if (rd_en) begin
         data_out_q <= rd_data;
      end
   end

   assign bus.o_data_out = data_out_q;

endmodule

// File: tb/tb_rf_path_seq_ctrl.sv
// Directed self-checking bench for rf_path_seq_ctrl (both RF_PATH_DEBUG_EN builds).
module tb_rf_path_seq_ctrl;

   localparam int unsigned N_CH = 2;
   localparam int unsigned G    = 4;
   localparam int unsigned S    = 16;

   logic               clk;
   logic               rst;
   logic [8*N_CH-1:0]  rf_pins;
   logic [N_CH-1:0]    busy;
   int                 n_tests;
   int                 n_fail;

   rf_path_seq_ctrl_if bus ();

   rf_path_seq_ctrl #(
      .N_CH       (N_CH),
      .GUARD_CYC  (G),
      .SETTLE_CYC (S)
   ) dut (
      .i_sys_clk (clk),
      .i_rst     (rst),
      .bus       (bus),
      .o_rf_pins (rf_pins),
      .o_busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       is_wr;
      logic [4:0] addr;
      logic [7:0] data;
      logic [7:0] exp_rd;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic bus_wr(input logic [4:0] addr, input logic [7:0] data);
      bus.i_cs = 1'b1; bus.i_load_cmd = 1'b1; bus.i_fetch_cmd = 1'b0;
      bus.i_ioc = addr; bus.i_data_in = data;
      tick();
      bus.i_cs = 1'b0; bus.i_load_cmd = 1'b0;
   endtask

   task automatic bus_rd(input logic [4:0] addr, output logic [7:0] data);
      bus.i_cs = 1'b1; bus.i_fetch_cmd = 1'b1; bus.i_load_cmd = 1'b0;
      bus.i_ioc = addr;
      tick();
      bus.i_cs = 1'b0; bus.i_fetch_cmd = 1'b0;
      data = bus.o_data_out;
   endtask

   // Entered one cycle after the mode write; walks SAFE, SWITCH, ENABLE, IDLE.
   task automatic run_seq(input int ch, input logic [7:0] p_safe, input logic [7:0] p_sw,
                          input logic [7:0] p_tgt, input string tag);
      logic [7:0] exp_p;
      logic       exp_b;
      for (int t = 1; t <= int'(G + S + 2); t++) begin
         exp_p = (t <= int'(G)) ? p_safe : (t <= int'(G + S)) ? p_sw : p_tgt;
         exp_b = (t <= int'(G + S + 1));
         check($sformatf("%s pins t=%0d", tag, t), rf_pins[8*ch +: 8], exp_p);
         check($sformatf("%s busy t=%0d", tag, t), busy[ch], exp_b);
         if (t < int'(G + S + 2)) tick();
      end
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       vecs [18];
      logic [7:0] rd;

      vecs[0]  = '{1'b0, 5'h00, 8'h00, 8'h02};
      vecs[1]  = '{1'b0, 5'h01, 8'h00, 8'h00};
      vecs[2]  = '{1'b0, 5'h02, 8'h00, 8'h00};
      vecs[3]  = '{1'b0, 5'h04, 8'h00, 8'h00};
      vecs[4]  = '{1'b0, 5'h05, 8'h00, 8'h00};
      vecs[5]  = '{1'b0, 5'h1F, 8'h00, 8'h00};
      vecs[6]  = '{1'b1, 5'h01, 8'h01, 8'h00};
      vecs[7]  = '{1'b0, 5'h01, 8'h00, 8'h01};
      vecs[8]  = '{1'b1, 5'h01, 8'h02, 8'h00};
      vecs[9]  = '{1'b0, 5'h01, 8'h00, 8'h01};
      vecs[10] = '{1'b1, 5'h01, 8'h09, 8'h00};
      vecs[11] = '{1'b0, 5'h01, 8'h00, 8'h01};
      vecs[12] = '{1'b1, 5'h01, 8'h00, 8'h00};
      vecs[13] = '{1'b0, 5'h01, 8'h00, 8'h00};
      vecs[14] = '{1'b1, 5'h07, 8'hFF, 8'h00};
      vecs[15] = '{1'b0, 5'h07, 8'h00, 8'h00};
      vecs[16] = '{1'b1, 5'h02, 8'h00, 8'h00};
      vecs[17] = '{1'b0, 5'h02, 8'h00, 8'h00};

      n_tests = 0;
      n_fail  = 0;
      bus.i_cs = 1'b0; bus.i_fetch_cmd = 1'b0; bus.i_load_cmd = 1'b0;
      bus.i_ioc = '0; bus.i_data_in = '0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      check("reset pins", rf_pins, 16'h5656);
      check("reset busy", busy, 2'b00);
      check("reset data_out", bus.o_data_out, 8'h00);

      for (int i = 0; i < 18; i++) begin
         if (vecs[i].is_wr) begin
            bus_wr(vecs[i].addr, vecs[i].data);
         end else begin
            bus_rd(vecs[i].addr, rd);
            check($sformatf("vec%0d read 0x%0h", i, vecs[i].addr), rd, vecs[i].exp_rd);
         end
         check($sformatf("vec%0d busy", i), busy, 2'b00);
         check($sformatf("vec%0d pins", i), rf_pins, 16'h5656);
      end

      bus_rd(5'h00, rd);
      bus_wr(5'h01, 8'h00);
      tick();
      check("data_out held", bus.o_data_out, 8'h02);

      // rx_lpf on ch0 from reset
      bus_wr(5'h02, 8'h08);
      run_seq(0, 8'h56, 8'h9E, 8'h9D, "rxlpf");
      check("rxlpf ch1 untouched", rf_pins[15:8], 8'h56);

      // tx_hpf, restarted to rx_hpf on the 3rd SWITCH cycle
      bus_wr(5'h02, 8'h14);
      check("txhpf safe first", rf_pins[7:0], 8'h9E);
      tick(); tick(); tick();
      check("txhpf safe last", rf_pins[7:0], 8'h9E);
      tick();
      check("txhpf switch", rf_pins[7:0], 8'hAE);
      tick(); tick();
      bus_wr(5'h02, 8'h0C);
      run_seq(0, 8'hAE, 8'h5E, 8'h5D, "restart");

      // bypass on ch1
      bus_wr(5'h01, 8'h01);
      bus_wr(5'h02, 8'h04);
      check("ch1 safe", rf_pins[15:8], 8'h56);
      bus_rd(5'h04, rd);
      check("status during seq", rd, 8'h02);
      check("busy during ch1 seq", busy, 2'b10);
      check("ch0 during ch1 seq", rf_pins[7:0], 8'h5D);
      tick(); tick(); tick();
      check("ch1 switch", rf_pins[15:8], 8'h66);
      for (int i = 0; i < int'(S); i++) tick();
      check("ch1 target", rf_pins[15:8], 8'h66);
      check("ch1 busy at enable", busy, 2'b10);
      tick();
      check("ch1 busy done", busy, 2'b00);
      bus_rd(5'h04, rd);
      check("status idle", rd, 8'h00);
      check("ch0 after ch1 seq", rf_pins[7:0], 8'h5D);

      // ch0 back to low_power
      bus_wr(5'h01, 8'h00);
      bus_wr(5'h02, 8'h00);
      run_seq(0, 8'h5E, 8'h56, 8'h56, "lowpwr");

      // debug override
      bus_wr(5'h03, 8'hFF);
      bus_wr(5'h02, 8'h01);
`ifdef RF_PATH_DEBUG_EN
      check("dbg pins", rf_pins[7:0], 8'hFF);
      check("dbg busy", busy, 2'b00);
      bus_rd(5'h02, rd);
      check("dbg mode readback", rd, 8'h01);
      bus_rd(5'h03, rd);
      check("dbg rf_pin readback", rd, 8'hFF);
      bus_wr(5'h02, 8'h00);
      run_seq(0, 8'hFE, 8'h56, 8'h56, "dbgexit");
`else
      check("nodbg pins", rf_pins[7:0], 8'h56);
      check("nodbg busy", busy, 2'b00);
      bus_rd(5'h02, rd);
      check("nodbg mode readback", rd, 8'h00);
      bus_rd(5'h03, rd);
      check("nodbg rf_pin readback", rd, 8'h00);
`endif

      // fetch and load together: read only
      bus.i_cs = 1'b1; bus.i_fetch_cmd = 1'b1; bus.i_load_cmd = 1'b1;
      bus.i_ioc = 5'h02; bus.i_data_in = 8'h08;
      tick();
      bus.i_cs = 1'b0; bus.i_fetch_cmd = 1'b0; bus.i_load_cmd = 1'b0;
      check("fetch+load data", bus.o_data_out, 8'h00);
      check("fetch+load busy", busy, 2'b00);
      tick(); tick();
      check("fetch+load pins", rf_pins[7:0], 8'h56);
      bus_rd(5'h02, rd);
      check("fetch+load mode kept", rd, 8'h00);

      // reset mid-sequence
      bus_wr(5'h02, 8'h08);
      for (int i = 0; i < 6; i++) tick();
      check("pre-reset switch", rf_pins[7:0], 8'h9E);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midreset pins", rf_pins, 16'h5656);
      check("midreset busy", busy, 2'b00);
      check("midreset data_out", bus.o_data_out, 8'h00);
      bus_rd(5'h02, rd);
      check("midreset mode", rd, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
